instr_prefetch_buffer: RTL and testbench
========================================

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameters: DEPTH, default 4, FIFO entries (power of 2, >=2); MAX_OUTST, default 2, maximum outstanding memory requests; RESET_PC, default 32'h0000_0000, first fetch address.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 mem_req  output  1  fetch request valid.
REQ-005 mem_addr  output  32  word-aligned fetch address.
REQ-006 mem_gnt  input  1  request accepted this cycle.
REQ-007 mem_rvalid  input  1  read data valid; responses return in request order.
REQ-008 mem_rdata  input  32  instruction word.
REQ-009 flush  input  1  redirect from execute-stage branch resolution (PCSrcE).
REQ-010 flush_pc  input  32  redirect target (PCTargetE).
REQ-011 stall  input  1  fetch stage cannot accept an instruction this cycle.
REQ-012 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-013 instr  output  32  head instruction word; 0 when empty.
REQ-014 instr_pc  output  32  head instruction address; 0 when empty.
REQ-015 instr_pc4  output  32  instr_pc + 4, modulo 2^32; 0 when empty.

Function
REQ-016 Issue: mem_req = 1 when not flush and (FIFO occupancy + outstanding) < DEPTH and outstanding < MAX_OUTST.
REQ-017 Request is accepted only in a cycle with mem_req && mem_gnt; fetch_pc then increments by 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding increments.
REQ-018 While mem_req && !mem_gnt, mem_addr stays stable unless flush is asserted.
REQ-019 Each mem_rvalid while drop_cnt = 0 writes {mem_rdata, request PC} into the FIFO; the entry is visible on instr_* the next cycle (latency 1 from rvalid).
REQ-020 Each mem_rvalid while drop_cnt > 0 is discarded and decrements drop_cnt; outstanding decrements on every rvalid.
REQ-021 mem_rvalid with outstanding = 0 is ignored with no state change.
REQ-022 Pop: head is removed when instr_valid && !stall && !flush.
REQ-023 Simultaneous push and pop when full: both are performed and occupancy is unchanged; there is no empty-FIFO bypass.
REQ-024 Flush cycle: mem_req = 0; FIFO is emptied; fetch_pc <= flush_pc; drop_cnt <= outstanding - mem_rvalid; any rvalid in that cycle is discarded.
REQ-025 Flush cycle: instr_valid = 0 combinationally and no pop occurs.
REQ-026 Issue may resume the cycle after a flush while drop_cnt > 0; stale responses are consumed first by in-order return.
REQ-027 Flush while drop_cnt > 0: drop_cnt <= outstanding - mem_rvalid; a flush never accumulates stale responses twice.
REQ-028 Track response PCs in a MAX_OUTST-deep in-order PC queue written at grant and read at rvalid.
REQ-029 Pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare and wrap without loss.

Reset
REQ-030 rst low, immediately and asynchronously: FIFO empty, outstanding = 0, drop_cnt = 0, fetch_pc = RESET_PC, mem_req = 0, instr_valid = 0, instr/instr_pc/instr_pc4 = 0.
REQ-031 First mem_req = 1 with mem_addr = RESET_PC occurs in the first cycle after rst rises.
REQ-032 Reset mid-transaction abandons in-flight responses; the memory is reset together with this block.

Structure
REQ-033 XLEN (32), RESET_PC default, and the NOP encoding 32'h0000_0013 are defined in the shared core constants package/include.
REQ-034 FIFO storage, pointers, and full/empty logic form one sub-module, prefetch_fifo; issue, drop, and PC-queue logic stay in the top.

Verification
REQ-035 Reset release, mem_gnt tied 1, rvalid 1 cycle after grant with rdata = PC ^ 32'hA5A5_0000 -> instr_pc sequence 0, 4, 8, 12 with matching data; first instr_valid 3 cycles after rst rises.
REQ-036 stall held 10 cycles -> occupancy reaches 4; mem_req low while (occupancy + outstanding) = 4; no data lost; release -> 4 in-order pops.
REQ-037 flush with flush_pc = 32'h0000_0100 and 2 outstanding -> the next 2 rvalids are discarded; first instr_pc after flush = 32'h100.
REQ-038 flush and mem_rvalid in the same cycle with 1 outstanding -> drop_cnt = 0; the next grant address = flush_pc.
REQ-039 mem_gnt held low 5 cycles -> mem_addr stable throughout; flush in cycle 3 -> mem_addr = flush_pc in cycle 4.
REQ-040 fetch_pc = 32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc4 of FFFF_FFFC = 0.

Source files
------------

// File: rtl/instr_prefetch_buffer_pkg.sv
// instr_prefetch_buffer_pkg: shared core constants and fetch types.
// Provides XLEN, the default reset PC, the NOP encoding, the FIFO entry
// layout and the sequential-PC helper used across the prefetch slice.
package instr_prefetch_buffer_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction
endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// prefetch_fifo: instruction FIFO storage with wrap-bit pointers.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         empties the FIFO (overrides push/pop)
//   push, wdata   write request and entry
//   pop           remove the head entry
//   rdata         head entry
//   empty, count  status and occupancy
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full, do_push, do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    always_comb begin
        empty   = wr_ptr == rd_ptr;
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count   = wr_ptr - rd_ptr;
        do_pop  = pop && !empty && !clear;
        do_push = push && !clear && (!full || do_pop);
        rdata   = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: in-order instruction prefetcher with flush handling.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   mem_req, mem_addr          fetch request and word address
//   mem_gnt                    request accepted this cycle
//   mem_rvalid, mem_rdata      in-order read response
//   flush, flush_pc            redirect and its target
//   stall                      fetch stage cannot take an instruction
//   instr_valid, instr         head instruction (0 when empty)
//   instr_pc, instr_pc4        head address and address + 4 (0 when empty)
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc4
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outst, drop_cnt;
    logic [XLEN-1:0] pcq [MAX_OUTST];
    logic [QW-1:0]   pcq_wr, pcq_rd;
    logic [AW:0]     occ;
    logic            fifo_empty, accept, resp, push;
    fetch_entry_t    head, wentry;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] i);
        return (i == QW'(MAX_OUTST - 1)) ? '0 : i + 1'b1;
    endfunction

    // Issue is gated by rst so nothing is requested while held in reset.
    // Responses with nothing outstanding are ignored entirely.
    always_comb begin
        mem_req     = rst && !flush && (int'(occ) + int'(outst) < DEPTH) && (int'(outst) < MAX_OUTST);
        mem_addr    = fetch_pc;
        accept      = mem_req && mem_gnt;
        resp        = mem_rvalid && (outst != '0);
        push        = resp && (drop_cnt == '0) && !flush;
        wentry      = '{data: mem_rdata, pc: pcq[pcq_rd]};
        instr_valid = !fifo_empty && !flush;
        instr       = fifo_empty ? '0 : head.data;
        instr_pc    = fifo_empty ? '0 : head.pc;
        instr_pc4   = fifo_empty ? '0 : pc_next(head.pc);
    end

    // On flush every still-outstanding response (minus one returning now)
    // becomes stale; this overwrites rather than adds to drop_cnt because
    // earlier stale responses are already counted in outst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            drop_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
        end else begin
            fetch_pc <= flush ? flush_pc : accept ? pc_next(fetch_pc) : fetch_pc;
            outst    <= outst + OW'(accept) - OW'(resp);
            drop_cnt <= flush ? outst - OW'(resp) : (resp && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
            pcq_wr   <= accept ? q_inc(pcq_wr) : pcq_wr;
            pcq_rd   <= resp ? q_inc(pcq_rd) : pcq_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pcq[pcq_wr] <= fetch_pc;
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (instr_valid && !stall),
        .wdata (wentry),
        .rdata (head),
        .empty (fifo_empty),
        .count (occ)
    );
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: scoreboard bench with an in-order memory model.
module tb_instr_prefetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_gnt, mem_rvalid, flush, stall, instr_valid;
    logic [31:0] mem_addr, mem_rdata, flush_pc, instr, instr_pc, instr_pc4;

    always #5 clk = ~clk;

    instr_prefetch_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pc4   (instr_pc4)
    );

    typedef struct {
        logic [31:0] addr;
        int          ep;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    logic [31:0] fpc;
    int          epoch, n_chk, n_pass;
    bit          resp_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: sample and score at negedge, advance the model and drive
    // the memory response just after the rising edge.
    task automatic tick();
        logic        acc, rv;
        logic [31:0] a, e;
        @(negedge clk);
        check("mem_req", mem_req, !flush && (sb.size() + pend.size() < 4) && (pend.size() < 2));
        if (mem_req) check("mem_addr", mem_addr, fpc);
        check("instr_valid", instr_valid, sb.size() != 0 && !flush);
        if (sb.size() == 0) begin
            check("instr_empty", instr, 32'h0);
            check("pc_empty", instr_pc, 32'h0);
            check("pc4_empty", instr_pc4, 32'h0);
        end else if (instr_valid && !stall) begin
            e = sb.pop_front();
            check("instr_pc", instr_pc, e);
            check("instr", instr, e ^ 32'hA5A5_0000);
            check("instr_pc4", instr_pc4, e + 32'd4);
        end
        acc = mem_req && mem_gnt;
        a   = mem_addr;
        rv  = mem_rvalid && pend.size() != 0;
        if (rv && !flush) begin
            if (pend[0].ep == epoch) sb.push_back(pend[0].addr);
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
        if (rv) void'(pend.pop_front());
        if (acc) pend.push_back('{a, epoch});
        if (flush) begin
            epoch++;
            fpc = flush_pc;
        end else if (acc) fpc += 32'd4;
        mem_rvalid = resp_en && pend.size() != 0;
        mem_rdata  = 32'h0;
        if (mem_rvalid) mem_rdata = pend[0].addr ^ 32'hA5A5_0000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        flush = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 32'h0);
        check("rst_valid", instr_valid, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc4", instr_pc4, 32'h0);
        pend.delete();
        sb.delete();
        fpc = 32'h0;
        epoch++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain();
        mem_gnt = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 20 && pend.size() != 0; i++) tick();
        check("drain", pend.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_gnt = 1'b0;
        stall = 1'b0;
        flush_pc = 32'h0;
        resp_en = 1'b1;
        #1;
        do_reset();
        // Streaming fetch, then first-valid timing
        mem_gnt = 1'b1;
        tick();
        tick();
        check("first_valid", instr_valid, 32'h1);
        repeat (6) tick();
        // Stall fills FIFO to DEPTH, then releases in order
        stall = 1'b1;
        repeat (10) tick();
        check("occ_full", sb.size(), 32'd4);
        check("full_valid", instr_valid, 32'h1);
        stall = 1'b0;
        repeat (6) tick();
        // Flush with two outstanding: both stale responses dropped
        resp_en = 1'b0;
        for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
        check("two_outst", pend.size(), 32'd2);
        flush = 1'b1;
        flush_pc = 32'h0000_0100;
        tick();
        flush = 1'b0;
        resp_en = 1'b1;
        repeat (10) tick();
        // Flush coincident with the only outstanding response
        drain();
        mem_gnt = 1'b1;
        resp_en = 1'b0;
        tick();
        mem_gnt = 1'b0;
        resp_en = 1'b1;
        tick();
        check("rv_pending", mem_rvalid, 32'h1);
        flush = 1'b1;
        flush_pc = 32'h0000_0200;
        tick();
        flush = 1'b0;
        mem_gnt = 1'b1;
        repeat (6) tick();
        // Grant withheld, flush in the third cycle redirects mem_addr
        drain();
        tick();
        tick();
        flush = 1'b1;
        flush_pc = 32'h0000_0300;
        tick();
        flush = 1'b0;
        tick();
        check("redir_addr", mem_addr, 32'h0000_0300);
        tick();
        mem_gnt = 1'b1;
        repeat (6) tick();
        // Address wrap at the top of the space
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        // Spurious response with nothing outstanding
        drain();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        repeat (2) tick();
        // Reset while requests are in flight
        mem_gnt = 1'b1;
        resp_en = 1'b0;
        repeat (2) tick();
        do_reset();
        resp_en = 1'b1;
        repeat (6) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
